// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter:
//   - ALUctr operation codes understood by the ALU
//   - arbiter FSM state encoding
//   - requester port id type (P0 = 0, P1 = 1)
package alu_share_arbiter_pkg;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Single-cycle 32-bit ALU shared by both requester ports.
// Ports:
//   a, b      operands
//   ctr       ALUctr operation code
//   result    combinational result
//   zero      result == 0
//   overflow  signed overflow, only for the trapping ADD/SUB codes
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   ctr,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         overflow
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ctr)
      ALU_ADDU: result = sum;
      ALU_ADD: begin
        result   = sum;
        // Same-sign operands producing a different-sign sum.
        overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_OR:   result = a | b;
      ALU_SUBU: result = diff;
      ALU_SUB: begin
        result   = diff;
        // Opposite-sign operands where the difference takes b's sign.
        overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      ALU_SLTU: result = {{(W-1){1'b0}}, (a < b)};
      ALU_SLT:  result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between requester ports P0 and P1.
// One op is in flight at a time: accept (valid/ready) -> execute from
// latched operands -> hold registered result until the owner consumes it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-port request handshake
//   req_a/b/ctr       per-port operands and ALUctr code
//   rsp_valid/ready   per-port response handshake
//   rsp_result/zero/ovf  registered ALU outputs, shared by both ports
//   busy              high while an op is in EXEC or RESP
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational from req_valid
// EXEC  | ALU evaluates latched operands; outputs captured at end of cycle
// RESP  | rsp_valid[owner] held with stable result until rsp_ready[owner]
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int W        = 32,
  parameter bit P0_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0][W-1:0]  req_a,
  input  logic [1:0][W-1:0]  req_b,
  input  logic [1:0][2:0]    req_ctr,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [W-1:0]       rsp_result,
  output logic               rsp_zero,
  output logic               rsp_ovf,
  output logic               busy
);

  // rr_last = 1 after reset makes P0 the first winner of a tie.
  localparam port_id_t RR_RESET = P0_FIRST ? 1'b1 : 1'b0;

  state_t       state;
  port_id_t     owner;
  port_id_t     rr_last;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]   ctr_q;

  logic [1:0]   gnt;
  port_id_t     gnt_id;
  logic         accept;

  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         alu_ovf;

  always_comb begin
    gnt = 2'b00;
    case (req_valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign gnt_id = gnt[1];
  // Gated with rst_n so ready is also low while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? gnt : 2'b00;
  assign accept    = |req_ready;

  alu_share_arbiter_alu #(.W(W)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .ctr      (ctr_q),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_last    <= RR_RESET;
      a_q        <= '0;
      b_q        <= '0;
      ctr_q      <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= req_a[gnt_id];
            b_q     <= req_b[gnt_id];
            ctr_q   <= req_ctr[gnt_id];
            owner   <= gnt_id;
            rr_last <= gnt_id;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_ovf    <= alu_ovf;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table,
// randomized ops against a behavioural ALU/arbitration model, and
// hand-written sequences for reset mid-op and stray handshakes.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_a;
  logic [1:0][31:0]  req_b;
  logic [1:0][2:0]   req_ctr;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_result;
  logic              rsp_zero;
  logic              rsp_ovf;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic m_rr;  // model: port that won the last grant

  alu_share_arbiter #(.W(32), .P0_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctr    (req_ctr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void alu_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] c, output logic [31:0] r,
                                    output logic z, output logic o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0;
    o = 1'b0;
    case (c)
      ALU_ADDU: r = a + b;
      ALU_ADD: begin s = sa + sb; r = s[31:0]; o = (s > SMAX) || (s < SMIN); end
      ALU_OR:   r = a | b;
      ALU_SUBU: r = a - b;
      ALU_SUB: begin s = sa - sb; r = s[31:0]; o = (s > SMAX) || (s < SMIN); end
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      default:  r = 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  // Called ~1 time unit after a rising edge. Runs one full op: request with
  // valid mask, EXEC, RESP held for 'stall' cycles with rsp_ready low on the
  // owner (stray rsp_ready on the other port), then consumption. If pend is
  // set the losing port keeps a pending request through EXEC/RESP.
  task automatic issue(input logic [1:0] mask,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                       input int stall, input bit pend,
                       output logic w, output logic [31:0] res, output logic z, output logic o);
    logic [1:0]  exp_g, own_v, stray_r;
    logic [31:0] mr;
    logic        mz, mo;
    req_a[0] = a0; req_b[0] = b0; req_ctr[0] = c0;
    req_a[1] = a1; req_b[1] = b1; req_ctr[1] = c1;
    req_valid = mask;
    @(negedge clk);
    exp_g = (mask == 2'b11) ? (m_rr ? 2'b01 : 2'b10) : mask;
    w = exp_g[1];
    own_v   = w ? 2'b10 : 2'b01;
    stray_r = w ? 2'b01 : 2'b10;
    chk("idle_grant", 32'(req_ready), 32'(exp_g));
    chk("idle_busy_rsp", 32'({busy, rsp_valid}), 32'd0);
    alu_model(w ? a1 : a0, w ? b1 : b0, w ? c1 : c0, mr, mz, mo);
    @(posedge clk); #1;
    req_valid = 2'b00;
    if (pend) req_valid[~w] = 1'b1;
    rsp_ready = 2'b11;  // ignored in EXEC
    @(negedge clk);
    chk("exec_state", 32'({busy, rsp_valid, req_ready}), 32'b10000);
    @(posedge clk); #1;
    rsp_ready = (stall == 0) ? own_v : stray_r;
    @(negedge clk);
    chk("resp_valid", 32'(rsp_valid), 32'(own_v));
    chk("resp_result", rsp_result, mr);
    chk("resp_flags", 32'({rsp_zero, rsp_ovf}), 32'({mz, mo}));
    res = rsp_result; z = rsp_zero; o = rsp_ovf;
    for (int k = 1; k <= stall; k++) begin
      @(posedge clk); #1;
      rsp_ready = (k == stall) ? own_v : stray_r;
      @(negedge clk);
      chk("stall_stable", 32'({busy, rsp_valid, rsp_zero, rsp_ovf}), 32'({1'b1, own_v, z, o}));
      chk("stall_result", rsp_result, res);
      chk("stall_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    m_rr = w;
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] a0, b0;
    logic [2:0]  c0;
    logic [31:0] a1, b1;
    logic [2:0]  c1;
    int          stall;
    bit          pend;
    logic [31:0] exp_res;
    logic        exp_z, exp_o;
    logic        exp_port;
  } vec_t;

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
      default: return $urandom;
    endcase
  endfunction

  vec_t        tbl[9];
  logic [2:0]  ops[7];
  logic        w;
  logic [31:0] res;
  logic        z, o;

  initial begin
    ops = '{ALU_ADDU, ALU_ADD, ALU_OR, ALU_SUBU, ALU_SUB, ALU_SLTU, ALU_SLT};
    tbl[0] = '{2'b11, 32'd7, 32'd7, ALU_SUBU, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 32'd7, 32'd7, ALU_SUBU, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 0, 1'b0, 32'd1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{2'b11, 32'd5, 32'd3, ALU_ADDU, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 1, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 32'd5, 32'd3, ALU_ADDU, 32'd0, 32'd0, ALU_OR, 2, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{2'b10, 32'hFFFF_FFFF, 32'd1, ALU_ADDU, 32'h7FFF_FFFF, 32'd1, ALU_ADD, 5, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{2'b01, 32'hFFFF_FFFF, 32'd1, ALU_ADDU, 32'h7FFF_FFFF, 32'd1, ALU_ADD, 0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{2'b11, 32'hF0F0_0000, 32'h0000_0F0F, ALU_OR, 32'h8000_0000, 32'd1, ALU_SUB, 0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{2'b01, 32'hF0F0_0000, 32'h0000_0F0F, ALU_OR, 32'h8000_0000, 32'd1, ALU_SUB, 1, 1'b0, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{2'b10, 32'd0, 32'd0, ALU_ADDU, 32'hFFFF_FFFF, 32'd1, ALU_SLTU, 0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};

    // Reset: requests held valid must not be granted while rst_n is low.
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = '0; req_b = '0; req_ctr = '0;
    rsp_ready = 2'b00;
    m_rr = 1'b1;
    #12;
    chk("reset_outputs", 32'({req_ready, rsp_valid, busy, rsp_zero, rsp_ovf}), 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      issue(tbl[i].mask, tbl[i].a0, tbl[i].b0, tbl[i].c0, tbl[i].a1, tbl[i].b1, tbl[i].c1,
            tbl[i].stall, tbl[i].pend, w, res, z, o);
      chk($sformatf("vec%0d_port", i), 32'(w), 32'(tbl[i].exp_port));
      chk($sformatf("vec%0d_result", i), res, tbl[i].exp_res);
      chk($sformatf("vec%0d_flags", i), 32'({z, o}), 32'({tbl[i].exp_z, tbl[i].exp_o}));
      req_valid = 2'b00;
      @(posedge clk); #1;
    end

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(1, 3)),
            rnd32(), rnd32(), ops[$urandom_range(0, 6)],
            rnd32(), rnd32(), ops[$urandom_range(0, 6)],
            $urandom_range(0, 2), 1'b0, w, res, z, o);
      req_valid = 2'b00;
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end

    // P0 raises valid, then withdraws before the edge: nothing is issued.
    req_valid = 2'b01;
    @(negedge clk);
    chk("drop_ready_seen", 32'(req_ready), 32'b01);
    #1 req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drop_no_op", 32'({busy, rsp_valid}), 32'd0);
    end
    @(posedge clk); #1;

    // Reset during EXEC: op discarded, rr_last restored.
    issue(2'b01, 32'hF0F0_0000, 32'h0000_0F0F, ALU_OR, 32'd0, 32'd0, ALU_ADDU,
          0, 1'b0, w, res, z, o);
    req_valid = 2'b01;
    req_a[0] = 32'd1; req_b[0] = 32'd2; req_ctr[0] = ALU_ADDU;
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", 32'({req_ready, rsp_valid, busy, rsp_zero, rsp_ovf}), 32'd0);
    chk("midop_reset_result", rsp_result, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    m_rr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", 32'({busy, rsp_valid}), 32'd0);
    end
    @(posedge clk); #1;
    issue(2'b11, 32'd9, 32'd4, ALU_SUBU, 32'd2, 32'd3, ALU_ADD, 0, 1'b0, w, res, z, o);
    chk("post_reset_tie_p0", 32'(w), 32'd0);
    chk("post_reset_tie_result", res, 32'd5);
    req_valid = 2'b00;
    issue(2'b10, 32'd0, 32'd0, ALU_ADDU, 32'd2, 32'd3, ALU_ADD, 1, 1'b0, w, res, z, o);
    chk("post_reset_p1_result", res, 32'd5);
    req_valid = 2'b00;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
